// File: rtl/cpu_6502_ISA_pkg.sv
// Shared definitions for the 6502 fetch sequencer: sequencer states,
// opcode-group and addressing-mode codes, implicit opcodes, reset PC.
package cpu_6502_ISA_pkg;

   localparam logic [15:0] RESET_PC_DEFAULT = 16'h8000;

   // Each request state has a matching *_WAIT phase that holds the
   // outstanding read until mem_rvalid returns.
   typedef enum logic [2:0] {
      S_FETCH,
      S_FETCH_WAIT,
      S_OP1,
      S_OP1_WAIT,
      S_OP2,
      S_OP2_WAIT,
      S_ISSUE
   } seq_state_t;

   // Opcode groups, selected by the low two bits (cc) of aaabbbcc
   localparam logic [1:0] CC_G1 = 2'b01;
   localparam logic [1:0] CC_G2 = 2'b10;
   localparam logic [1:0] CC_G3 = 2'b00;

   // Addressing-mode codes (bbb) that matter for length decoding
   localparam logic [2:0] G1_ABS     = 3'b011;
   localparam logic [2:0] G1_ABS_Y   = 3'b110;
   localparam logic [2:0] G1_ABS_X   = 3'b111;

   localparam logic [2:0] G2_IMM     = 3'b000;
   localparam logic [2:0] G2_ACC     = 3'b010;
   localparam logic [2:0] G2_ABS     = 3'b011;
   localparam logic [2:0] G2_ILLEGAL = 3'b100;
   localparam logic [2:0] G2_IMPL    = 3'b110;
   localparam logic [2:0] G2_ABS_X   = 3'b111;

   localparam logic [2:0] G3_ABS     = 3'b011;
   localparam logic [2:0] G3_ABS_X   = 3'b111;

   // Single-byte implicit opcodes outside the x8 column
   localparam logic [7:0] OP_BRK = 8'h00;
   localparam logic [7:0] OP_JSR = 8'h20;
   localparam logic [7:0] OP_RTI = 8'h40;
   localparam logic [7:0] OP_RTS = 8'h60;
   localparam logic [7:0] OP_TXA = 8'h8A;
   localparam logic [7:0] OP_TXS = 8'h9A;
   localparam logic [7:0] OP_TAX = 8'hAA;
   localparam logic [7:0] OP_TSX = 8'hBA;
   localparam logic [7:0] OP_DEX = 8'hCA;
   localparam logic [7:0] OP_NOP = 8'hEA;

   // Every x8 opcode (PHP, CLC, ..., SED) is implied-mode, one byte
   function automatic logic is_implicit(input logic [7:0] op);
      return (op[3:0] == 4'h8) ||
             (op inside {OP_BRK, OP_RTI, OP_RTS, OP_TXA, OP_TXS,
                         OP_TAX, OP_TSX, OP_DEX, OP_NOP});
   endfunction

endpackage

// File: rtl/cpu_6502_len_decode.sv
// Combinational instruction-length and illegal-opcode decoder.
module cpu_6502_len_decode
   import cpu_6502_ISA_pkg::*;
(
   input  logic [7:0] opcode,
   output logic [1:0] len,
   output logic       illegal
);

   logic [2:0] aaa;
   logic [2:0] bbb;
   logic [1:0] cc;

   assign aaa = opcode[7:5];
   assign bbb = opcode[4:2];
   assign cc  = opcode[1:0];

   // Classify by group, then by addressing mode
   always_comb begin
      // NOTE: both outputs get a default before any branch, so no path
      // leaves them unassigned and no latch is inferred.
      len     = 2'd2;
      illegal = 1'b0;
      if (is_implicit(opcode)) begin
         len = 2'd1;
      end else begin
         case (cc)
            CC_G1: begin
               if (bbb inside {G1_ABS, G1_ABS_Y, G1_ABS_X}) len = 2'd3;
            end
            CC_G2: begin
               // Column-0 opcodes 02/22/42/62 jam a real 6502; treat
               // them as undefined alongside the bbb=100 column.
               if (bbb == G2_ILLEGAL || (bbb == G2_IMM && !aaa[2])) begin
                  illegal = 1'b1;
                  len     = 2'd1;
               end else if (bbb inside {G2_ABS, G2_ABS_X}) begin
                  len = 2'd3;
               end else if (bbb inside {G2_ACC, G2_IMPL}) begin
                  len = 2'd1;
               end
            end
            CC_G3: begin
               if (opcode == OP_JSR) begin
                  len = 2'd3;
               end else if (aaa == 3'b000 && bbb[0]) begin
                  illegal = 1'b1;
                  len     = 2'd1;
               end else if (bbb inside {G3_ABS, G3_ABS_X}) begin
                  len = 2'd3;
               end
            end
            default: begin
               illegal = 1'b1;
               len     = 2'd1;
            end
         endcase
      end
   end

endmodule

// File: rtl/cpu_6502_fetch_seq.sv
// 6502 instruction fetch sequencer: reads opcode and operand bytes one at
// a time, presents the assembled instruction, and follows redirects.
module cpu_6502_fetch_seq
   import cpu_6502_ISA_pkg::*;
#(
   parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
)(
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_rvalid,
   input  logic [7:0]  mem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [7:0]  instr_opcode,
   output logic [7:0]  instr_op1,
   output logic [7:0]  instr_op2,
   output logic [1:0]  instr_len,
   output logic [15:0] instr_pc,
   output logic        instr_illegal,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc
);

   seq_state_t  state, state_n;
   logic [15:0] pc, pc_n;
   logic        discard, discard_n;
   logic        outstanding;
   logic        load_opcode, load_op1, load_op2;
   logic [1:0]  dec_len;
   logic        dec_illegal;

   cpu_6502_len_decode u_len_decode (
      .opcode  (mem_rdata),
      .len     (dec_len),
      .illegal (dec_illegal)
   );

   // A read is in flight in any wait phase, or while FETCH drains a stale one
   assign outstanding = (state == S_FETCH_WAIT) || (state == S_OP1_WAIT) ||
                        (state == S_OP2_WAIT)   || (state == S_FETCH && discard);

   // Requests are combinational so a read leaves in the same cycle the
   // state is entered; a redirect suppresses it since the PC is changing.
   assign mem_req = !rst && !redirect_valid &&
                    ((state == S_FETCH && !discard) ||
                     (state == S_OP1) || (state == S_OP2));

   // pc never moves while an instruction is being assembled or held
   assign instr_pc    = pc;
   assign instr_valid = (state == S_ISSUE);

   // Read address: opcode at pc, operands at pc+1 / pc+2
   always_comb begin
      mem_addr = pc;
      case (state)
         S_OP1:   mem_addr = pc + 16'd1;
         S_OP2:   mem_addr = pc + 16'd2;
         default: mem_addr = pc;
      endcase
   end

   // Next-state, next-pc, discard tracking and byte-capture strobes
   always_comb begin
      state_n     = state;
      pc_n        = pc;
      discard_n   = discard;
      load_opcode = 1'b0;
      load_op1    = 1'b0;
      load_op2    = 1'b0;
      if (redirect_valid) begin
         state_n   = S_FETCH;
         pc_n      = redirect_pc;
         // Data arriving this very cycle is simply dropped; otherwise the
         // in-flight read must be swallowed when it returns.
         discard_n = outstanding && !mem_rvalid;
      end else begin
         case (state)
            S_FETCH: begin
               if (discard) begin
                  if (mem_rvalid) discard_n = 1'b0;
               end else begin
                  state_n = S_FETCH_WAIT;
               end
            end
            S_FETCH_WAIT: begin
               if (mem_rvalid) begin
                  load_opcode = 1'b1;
                  state_n     = (dec_len == 2'd1) ? S_ISSUE : S_OP1;
               end
            end
            S_OP1: state_n = S_OP1_WAIT;
            S_OP1_WAIT: begin
               if (mem_rvalid) begin
                  load_op1 = 1'b1;
                  state_n  = (instr_len == 2'd3) ? S_OP2 : S_ISSUE;
               end
            end
            S_OP2: state_n = S_OP2_WAIT;
            S_OP2_WAIT: begin
               if (mem_rvalid) begin
                  load_op2 = 1'b1;
                  state_n  = S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (instr_ready) begin
                  pc_n    = pc + {14'd0, instr_len};
                  state_n = S_FETCH;
               end
            end
            default: state_n = S_FETCH;
         endcase
      end
   end

   // Sequencer state, program counter and discard flag
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of process ordering.
      if (rst) begin
         state   <= S_FETCH;
         pc      <= RESET_PC;
         discard <= 1'b0;
      end else begin
         state   <= state_n;
         pc      <= pc_n;
         discard <= discard_n;
      end
   end

   // Instruction holding registers; operands clear when a new opcode lands
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_opcode  <= 8'h00;
         instr_op1     <= 8'h00;
         instr_op2     <= 8'h00;
         instr_len     <= 2'd1;
         instr_illegal <= 1'b0;
      end else begin
         if (load_opcode) begin
            instr_opcode  <= mem_rdata;
            instr_op1     <= 8'h00;
            instr_op2     <= 8'h00;
            instr_len     <= dec_len;
            instr_illegal <= dec_illegal;
         end
         if (load_op1) instr_op1 <= mem_rdata;
         if (load_op2) instr_op2 <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_cpu_6502_fetch_seq.sv
// Self-checking bench for cpu_6502_fetch_seq: a table of single
// instructions at 8000 plus directed stall / redirect / wrap sequences.
module tb_cpu_6502_fetch_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_rvalid;
   logic [7:0]  mem_rdata;
   logic        instr_valid;
   logic [7:0]  instr_opcode, instr_op1, instr_op2;
   logic [1:0]  instr_len;
   logic [15:0] instr_pc;
   logic        instr_illegal;

   always #5 clk = ~clk;

   cpu_6502_fetch_seq dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_rvalid     (mem_rvalid),
      .mem_rdata      (mem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_opcode   (instr_opcode),
      .instr_op1      (instr_op1),
      .instr_op2      (instr_op2),
      .instr_len      (instr_len),
      .instr_pc       (instr_pc),
      .instr_illegal  (instr_illegal),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   // ---------------- memory model: fixed extra latency, one-cycle min ----
   logic [7:0]  mem [0:65535];
   logic        rv_q = 1'b0;
   logic [7:0]  rd_q = 8'h00;
   logic        busy = 1'b0;
   int          cnt = 0;
   logic [15:0] a_q = 16'h0000;
   int          lat = 0;
   int          overlap = 0;
   int          accepts = 0;
   logic        spur = 1'b0;
   logic [15:0] req_log[$];

   assign mem_rvalid = rv_q | spur;
   assign mem_rdata  = spur ? 8'hFF : rd_q;

   always @(posedge clk) begin
      if (rst) begin
         rv_q <= 1'b0;
         busy <= 1'b0;
      end else begin
         rv_q <= 1'b0;
         if (busy) begin
            if (cnt == 0) begin
               rv_q <= 1'b1;
               rd_q <= mem[a_q];
               busy <= 1'b0;
            end else begin
               cnt <= cnt - 1;
            end
         end
         if (mem_req) begin
            if (busy) overlap <= overlap + 1;
            if (lat == 0) begin
               rv_q <= 1'b1;
               rd_q <= mem[mem_addr];
            end else begin
               busy <= 1'b1;
               cnt  <= lat - 1;
               a_q  <= mem_addr;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (!rst && instr_valid && instr_ready) accepts <= accepts + 1;
      if (mem_req) req_log.push_back(mem_addr);
   end

   // ---------------- checking helpers ----------------
   int n_pass = 0;
   int n_checks = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mem_req",  32'(mem_req), 32'd0);
      check("rst_valid",    32'(instr_valid), 32'd0);
      check("rst_illegal",  32'(instr_illegal), 32'd0);
      check("rst_opcode",   32'(instr_opcode), 32'h00);
      check("rst_op1",      32'(instr_op1), 32'h00);
      check("rst_op2",      32'(instr_op2), 32'h00);
      check("rst_len",      32'(instr_len), 32'd1);
      check("rst_pc",       32'(instr_pc), 32'h8000);
      rst = 1'b0;
      #1;
      check("first_req",      32'(mem_req), 32'd1);
      check("first_req_addr", 32'(mem_addr), 32'h8000);
   endtask

   task automatic wait_valid(input int budget, output int cycles);
      cycles = 0;
      while (!instr_valid && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      check("valid_timeout", 32'(instr_valid), 32'd1);
   endtask

   typedef struct packed {
      logic [7:0] b0, b1, b2;
      logic [1:0] len;
      logic       ill;
      logic [7:0] e1, e2;
   } vec_t;

   vec_t vecs [21];

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int   cyc;
      int   a0;
      logic [15:0] exp_addr;

      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

      //           b0     b1     b2     len   ill   op1    op2
      vecs[0]  = '{8'hEA, 8'h55, 8'h66, 2'd1, 1'b0, 8'h00, 8'h00};  // NOP
      vecs[1]  = '{8'hAD, 8'h34, 8'h12, 2'd3, 1'b0, 8'h34, 8'h12};  // LDA abs
      vecs[2]  = '{8'hA9, 8'h05, 8'h66, 2'd2, 1'b0, 8'h05, 8'h00};  // LDA #
      vecs[3]  = '{8'h85, 8'h10, 8'h66, 2'd2, 1'b0, 8'h10, 8'h00};  // STA zp
      vecs[4]  = '{8'h02, 8'h55, 8'h66, 2'd1, 1'b1, 8'h00, 8'h00};  // jam
      vecs[5]  = '{8'h20, 8'h00, 8'h90, 2'd3, 1'b0, 8'h00, 8'h90};  // JSR
      vecs[6]  = '{8'h00, 8'h55, 8'h66, 2'd1, 1'b0, 8'h00, 8'h00};  // BRK
      vecs[7]  = '{8'hD0, 8'hFE, 8'h66, 2'd2, 1'b0, 8'hFE, 8'h00};  // BNE
      vecs[8]  = '{8'h0A, 8'h55, 8'h66, 2'd1, 1'b0, 8'h00, 8'h00};  // ASL A
      vecs[9]  = '{8'h9A, 8'h55, 8'h66, 2'd1, 1'b0, 8'h00, 8'h00};  // TXS
      vecs[10] = '{8'hBE, 8'h34, 8'h12, 2'd3, 1'b0, 8'h34, 8'h12};  // LDX abs,Y
      vecs[11] = '{8'h1C, 8'h55, 8'h66, 2'd1, 1'b1, 8'h00, 8'h00};  // cc=00 aaa=000 odd bbb
      vecs[12] = '{8'h03, 8'h55, 8'h66, 2'd1, 1'b1, 8'h00, 8'h00};  // cc=11
      vecs[13] = '{8'h7D, 8'h34, 8'h12, 2'd3, 1'b0, 8'h34, 8'h12};  // ADC abs,X
      vecs[14] = '{8'h96, 8'h10, 8'h66, 2'd2, 1'b0, 8'h10, 8'h00};  // STX zp,Y
      vecs[15] = '{8'h92, 8'h55, 8'h66, 2'd1, 1'b1, 8'h00, 8'h00};  // cc=10 bbb=100
      vecs[16] = '{8'h4C, 8'h00, 8'hC0, 2'd3, 1'b0, 8'h00, 8'hC0};  // JMP abs
      vecs[17] = '{8'hBA, 8'h55, 8'h66, 2'd1, 1'b0, 8'h00, 8'h00};  // TSX
      vecs[18] = '{8'hA2, 8'h07, 8'h66, 2'd2, 1'b0, 8'h07, 8'h00};  // LDX #
      vecs[19] = '{8'h60, 8'h55, 8'h66, 2'd1, 1'b0, 8'h00, 8'h00};  // RTS
      vecs[20] = '{8'h61, 8'h20, 8'h66, 2'd2, 1'b0, 8'h20, 8'h00};  // ADC (zp,X)

      // ---------------- table: one instruction at 8000 each ----------------
      for (int v = 0; v < 21; v++) begin
         mem[16'h8000] = vecs[v].b0;
         mem[16'h8001] = vecs[v].b1;
         mem[16'h8002] = vecs[v].b2;
         mem[16'h8003] = 8'hEA;
         instr_ready = 1'b0;
         do_reset();
         req_log.delete();
         wait_valid(20, cyc);
         check("latency", 32'(cyc), 32'(2 + 2 * (int'(vecs[v].len) - 1)));
         check("opcode",  32'(instr_opcode), 32'(vecs[v].b0));
         check("op1",     32'(instr_op1), 32'(vecs[v].e1));
         check("op2",     32'(instr_op2), 32'(vecs[v].e2));
         check("len",     32'(instr_len), 32'(vecs[v].len));
         check("illegal", 32'(instr_illegal), 32'(vecs[v].ill));
         check("pc_out",  32'(instr_pc), 32'h8000);
         check("n_reads", 32'(req_log.size()), 32'(vecs[v].len));
         for (int k = 0; k < int'(vecs[v].len); k++) begin
            exp_addr = 16'h8000 + 16'(k);
            check("read_addr", (req_log.size() > k) ? 32'(req_log[k]) : 32'hDEAD, 32'(exp_addr));
         end
         instr_ready = 1'b1;
         @(negedge clk);
         instr_ready = 1'b0;
         exp_addr = 16'h8000 + {14'd0, vecs[v].len};
         check("b2b_req",      32'(mem_req), 32'd1);
         check("next_fetch",   32'(mem_addr), 32'(exp_addr));
         check("valid_drop",   32'(instr_valid), 32'd0);
      end

      // ---------------- ready held low, spurious rvalid ignored ----------
      mem[16'h8000] = 8'h85;
      mem[16'h8001] = 8'h10;
      mem[16'h8002] = 8'hEA;
      do_reset();
      wait_valid(20, cyc);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid",  32'(instr_valid), 32'd1);
         check("stall_opcode", 32'(instr_opcode), 32'h85);
         check("stall_op1",    32'(instr_op1), 32'h10);
         check("stall_len",    32'(instr_len), 32'd2);
         check("stall_no_req", 32'(mem_req), 32'd0);
         spur = (i == 2);
         @(negedge clk);
      end
      spur = 1'b0;
      a0 = accepts;
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      check("stall_accepts", 32'(accepts - a0), 32'd1);
      check("stall_next",    32'(mem_addr), 32'h8002);
      check("stall_req",     32'(mem_req), 32'd1);

      // ---------------- PC wrap: A9 05 at FFFF/0000 -----------------------
      mem[16'hFFFF] = 8'hA9;
      mem[16'h0000] = 8'h05;
      mem[16'h0001] = 8'hEA;
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFF;
      req_log.delete();
      @(negedge clk);
      redirect_valid = 1'b0;
      wait_valid(20, cyc);
      check("wrap_pc",   32'(instr_pc), 32'hFFFF);
      check("wrap_op1",  32'(instr_op1), 32'h05);
      check("wrap_len",  32'(instr_len), 32'd2);
      check("wrap_read", (req_log.size() > 1) ? 32'(req_log[1]) : 32'hDEAD, 32'h0000);
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      check("wrap_next", 32'(mem_addr), 32'h0001);
      check("wrap_req",  32'(mem_req), 32'd1);

      // ---------------- redirect while operand read outstanding ----------
      mem[16'h8000] = 8'hAD;
      mem[16'h8001] = 8'h34;
      mem[16'h8002] = 8'h12;
      mem[16'hC000] = 8'hEA;
      lat = 3;
      do_reset();
      for (int i = 0; i < 30 && !(mem_req && mem_addr == 16'h8001); i++) @(negedge clk);
      check("op1_req_seen", 32'(mem_req && mem_addr == 16'h8001), 32'd1);
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 16'hC000;
      req_log.delete();
      @(negedge clk);
      redirect_valid = 1'b0;
      wait_valid(40, cyc);
      check("redir_opcode",  32'(instr_opcode), 32'hEA);
      check("redir_pc",      32'(instr_pc), 32'hC000);
      check("redir_len",     32'(instr_len), 32'd1);
      check("redir_op1",     32'(instr_op1), 32'h00);
      check("redir_overlap", 32'(overlap), 32'd0);
      check("redir_first",   (req_log.size() > 0) ? 32'(req_log[0]) : 32'hDEAD, 32'hC000);

      // ---------------- reset while a read is outstanding ----------------
      mem[16'h8000] = 8'hEA;
      do_reset();
      @(negedge clk);
      do_reset();
      wait_valid(20, cyc);
      check("midrst_opcode", 32'(instr_opcode), 32'hEA);
      check("midrst_latency", 32'(cyc), 32'd5);
      lat = 0;

      // ---------------- redirect coincident with rvalid -----------------
      mem[16'h8000] = 8'hAD;
      do_reset();
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 16'hC000;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      check("coinc_req",  32'(mem_req), 32'd1);
      check("coinc_addr", 32'(mem_addr), 32'hC000);
      wait_valid(20, cyc);
      check("coinc_opcode", 32'(instr_opcode), 32'hEA);
      check("coinc_pc",     32'(instr_pc), 32'hC000);

      // ---------------- redirect in the accept cycle --------------------
      mem[16'h8000] = 8'hA9;
      mem[16'h8001] = 8'h05;
      do_reset();
      wait_valid(20, cyc);
      a0 = accepts;
      instr_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 16'hC000;
      @(negedge clk);
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      #1;
      check("racc_accepts", 32'(accepts - a0), 32'd1);
      check("racc_valid",   32'(instr_valid), 32'd0);
      check("racc_req",     32'(mem_req), 32'd1);
      check("racc_addr",    32'(mem_addr), 32'hC000);
      check("racc_pc",      32'(instr_pc), 32'hC000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
